// File: rtl/rv_pkg.sv
// Shared RISC-V core constants and types used by the data-bus arbiter.
package rv_pkg;

    localparam int XLEN           = 32;
    localparam int N_DATA_MASTERS = 2;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT
    } arb_state_t;

endpackage

// File: rtl/rv_data_arbiter.sv
// Round-robin arbiter sharing the data-memory bus between the LSU (m0) and the
// loader/debug port (m1); one transaction in flight, watchdog-terminated.
module rv_data_arbiter
    import rv_pkg::*;
#(
    parameter int unsigned     TIMEOUT_CYCLES = 16,
    parameter logic [XLEN-1:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic [N_DATA_MASTERS-1:0]                    m_req_i,
    input  logic [N_DATA_MASTERS-1:0]                    m_we_i,
    input  logic [N_DATA_MASTERS-1:0][XLEN/8-1:0]        m_be_i,
    input  logic [N_DATA_MASTERS-1:0][XLEN-1:0]          m_addr_i,
    input  logic [N_DATA_MASTERS-1:0][XLEN-1:0]          m_wdata_i,
    output logic [N_DATA_MASTERS-1:0]                    m_gnt_o,
    output logic [N_DATA_MASTERS-1:0]                    m_rvalid_o,
    output logic [XLEN-1:0]                              m_rdata_o,
    output logic [N_DATA_MASTERS-1:0]                    m_err_o,
    output logic                                         data_req_o,
    output logic                                         data_we_o,
    output logic [XLEN/8-1:0]                            data_be_o,
    output logic [XLEN-1:0]                              data_addr_o,
    output logic [XLEN-1:0]                              data_wdata_o,
    input  logic                                         data_rvalid_i,
    input  logic [XLEN-1:0]                              data_rdata_i,
    output logic                                         busy_o
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    // On a tie the master that did not win last time goes first.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) return ~last;
        return req[1];
    endfunction

    arb_state_t state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic [7:0] cnt_q, cnt_d;
    logic       we_q, we_d;
    logic [XLEN/8-1:0] be_q, be_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [N_DATA_MASTERS-1:0] rvalid_q, rvalid_d;
    logic [N_DATA_MASTERS-1:0] err_q, err_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              winner;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ARB_IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rvalid_q <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        be_d     = be_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rvalid_d = '0;
        err_d    = '0;
        rdata_d  = rdata_q;
        winner   = rr_pick(m_req_i, last_q);

        case (state_q)
            ARB_IDLE: begin
                // Late slave responses land here and are deliberately dropped.
                if (|m_req_i) begin
                    we_d    = m_we_i[winner];
                    be_d    = m_be_i[winner];
                    addr_d  = m_addr_i[winner];
                    wdata_d = m_wdata_i[winner];
                    owner_d = winner;
                    last_d  = winner;
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (data_rvalid_i) begin
                    rvalid_d[owner_q] = 1'b1;
                    rdata_d           = data_rdata_i;
                    state_d           = ARB_IDLE;
                end else begin
                    cnt_d   = '0;
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (data_rvalid_i) begin
                    rvalid_d[owner_q] = 1'b1;
                    rdata_d           = data_rdata_i;
                    state_d           = ARB_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    rvalid_d[owner_q] = 1'b1;
                    err_d[owner_q]    = 1'b1;
                    rdata_d           = ERR_RDATA;
                    state_d           = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign data_req_o   = (state_q == ARB_ISSUE);
    assign m_gnt_o      = {data_req_o & owner_q, data_req_o & ~owner_q};
    assign busy_o       = (state_q != ARB_IDLE);
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_addr_o  = addr_q;
    assign data_wdata_o = wdata_q;
    assign m_rvalid_o   = rvalid_q;
    assign m_err_o      = err_q;
    assign m_rdata_o    = rdata_q;

endmodule

// File: tb/tb_rv_data_arbiter.sv
// Bench for rv_data_arbiter: scripted vector table, corner-case sequences and a
// randomized run against a transaction-timing reference model.
module tb_rv_data_arbiter;
    import rv_pkg::*;

    localparam int T = 16;

    logic clk = 1'b0;
    logic rst;
    logic [1:0]        m_req, m_we, m_gnt, m_rvalid, m_err;
    logic [1:0][3:0]   m_be;
    logic [1:0][31:0]  m_addr, m_wdata;
    logic [31:0]       m_rdata;
    logic              data_req, data_we, data_rvalid, busy;
    logic [3:0]        data_be;
    logic [31:0]       data_addr, data_wdata, data_rdata;

    always #5 clk = ~clk;

    rv_data_arbiter #(.TIMEOUT_CYCLES(T), .ERR_RDATA(32'hDEAD_BEEF)) dut (
        .clk_i(clk), .rst_i(rst),
        .m_req_i(m_req), .m_we_i(m_we), .m_be_i(m_be), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
        .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata), .m_err_o(m_err),
        .data_req_o(data_req), .data_we_o(data_we), .data_be_o(data_be),
        .data_addr_o(data_addr), .data_wdata_o(data_wdata),
        .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata), .busy_o(busy)
    );

    typedef struct packed {
        logic        dreq;
        logic        we;
        logic [1:0]  gnt;
        logic [1:0]  rv;
        logic [1:0]  err;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        busy;
    } out_t;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic [31:0] wdata1;
        logic        rv;
        logic [31:0] rd;
        out_t        exp;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input out_t e);
        check({tag, ".data_req"}, 64'(data_req), 64'(e.dreq));
        check({tag, ".data_we"}, 64'(data_we), 64'(e.we));
        check({tag, ".gnt"}, 64'(m_gnt), 64'(e.gnt));
        check({tag, ".rvalid"}, 64'(m_rvalid), 64'(e.rv));
        check({tag, ".err"}, 64'(m_err), 64'(e.err));
        check({tag, ".rdata"}, 64'(m_rdata), 64'(e.rdata));
        check({tag, ".be"}, 64'(data_be), 64'(e.be));
        check({tag, ".addr"}, 64'(data_addr), 64'(e.addr));
        check({tag, ".wdata"}, 64'(data_wdata), 64'(e.wdata));
        check({tag, ".busy"}, 64'(busy), 64'(e.busy));
    endtask

    task automatic idle_inputs();
        m_req = '0; m_we = '0; m_be = '0; m_addr = '0; m_wdata = '0;
        data_rvalid = 1'b0; data_rdata = '0;
    endtask

    // Leaves the bench at the first negedge after reset with rst low again.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vecs[8];

    // reference-model state
    bit          md_active;
    int          md_issue;
    logic        md_own, md_last, md_we;
    logic [1:0]  md_rv, md_err;
    logic [31:0] md_rdata, md_addr, md_wdata;
    logic [3:0]  md_be;
    bit          silent;

    task automatic model_reset();
        md_active = 0; md_issue = 0; md_own = 0; md_last = 1; md_we = 0;
        md_rv = '0; md_err = '0; md_rdata = '0; md_addr = '0; md_wdata = '0; md_be = '0;
    endtask

    initial begin
        out_t e;
        logic prev_dreq;
        logic [1:0] eg;

        rst = 1'b1;
        idle_inputs();

        // ---------------- table: single read, zero-wait write, stray rvalid
        vecs[0] = '{2'b01, 2'b00, 32'h0000_0100, 32'h0, 32'h0, 1'b0, 32'h0,
                    '{1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0}};
        vecs[1] = '{2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                    '{1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 32'h0, 4'hF, 32'h0000_0100, 32'h1111_1111, 1'b1}};
        vecs[2] = '{2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 32'h1234_5678,
                    '{1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 4'hF, 32'h0000_0100, 32'h1111_1111, 1'b1}};
        vecs[3] = '{2'b10, 2'b10, 32'h0, 32'h8000_0000, 32'hA5A5_A5A5, 1'b0, 32'h0,
                    '{1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 32'h1234_5678, 4'hF, 32'h0000_0100, 32'h1111_1111, 1'b0}};
        vecs[4] = '{2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 32'hCAFE_0001,
                    '{1'b1, 1'b1, 2'b10, 2'b00, 2'b00, 32'h1234_5678, 4'h3, 32'h8000_0000, 32'hA5A5_A5A5, 1'b1}};
        vecs[5] = '{2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                    '{1'b0, 1'b1, 2'b00, 2'b10, 2'b00, 32'hCAFE_0001, 4'h3, 32'h8000_0000, 32'hA5A5_A5A5, 1'b0}};
        vecs[6] = '{2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0000_0BAD,
                    '{1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 32'hCAFE_0001, 4'h3, 32'h8000_0000, 32'hA5A5_A5A5, 1'b0}};
        vecs[7] = '{2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                    '{1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 32'hCAFE_0001, 4'h3, 32'h8000_0000, 32'hA5A5_A5A5, 1'b0}};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            check_outs($sformatf("vec%0d", i), vecs[i].exp);
            m_req = vecs[i].req;
            m_we = vecs[i].we;
            m_be[0] = 4'hF;
            m_be[1] = 4'h3;
            m_addr[0] = vecs[i].addr0;
            m_addr[1] = vecs[i].addr1;
            m_wdata[0] = 32'h1111_1111;
            m_wdata[1] = vecs[i].wdata1;
            data_rvalid = vecs[i].rv;
            data_rdata = vecs[i].rd;
            @(negedge clk);
        end

        // ---------------- tie fairness with a 1-cycle slave
        do_reset();
        m_req = 2'b11;
        prev_dreq = 1'b0;
        for (int k = 0; k < 13; k++) begin
            eg = ((k % 3) == 1) ? ((((k / 3) % 2) == 0) ? 2'b01 : 2'b10) : 2'b00;
            check($sformatf("tie.gnt%0d", k), 64'(m_gnt), 64'(eg));
            if (k >= 3) begin
                eg = ((k % 3) == 0) ? (((((k / 3) - 1) % 2) == 0) ? 2'b01 : 2'b10) : 2'b00;
                check($sformatf("tie.rvalid%0d", k), 64'(m_rvalid), 64'(eg));
            end
            data_rvalid = prev_dreq;
            prev_dreq = data_req;
            @(negedge clk);
        end

        // ---------------- watchdog timeout then a late slave answer
        do_reset();
        m_req = 2'b10;
        @(negedge clk);
        m_req = 2'b00;
        check("to.gnt", 64'(m_gnt), 64'(2'b10));
        @(negedge clk);
        for (int k = 0; k < T; k++) begin
            check($sformatf("to.wait_busy%0d", k), 64'(busy), 64'(1));
            check($sformatf("to.wait_rv%0d", k), 64'(m_rvalid), 64'(0));
            @(negedge clk);
        end
        check("to.rvalid", 64'(m_rvalid), 64'(2'b10));
        check("to.err", 64'(m_err), 64'(2'b10));
        check("to.rdata", 64'(m_rdata), 64'(32'hDEAD_BEEF));
        check("to.busy", 64'(busy), 64'(0));
        repeat (3) @(negedge clk);
        data_rvalid = 1'b1;
        data_rdata = 32'h5555_5555;
        @(negedge clk);
        data_rvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("to.late_rv", 64'(m_rvalid), 64'(0));
            check("to.late_busy", 64'(busy), 64'(0));
            check("to.late_rdata", 64'(m_rdata), 64'(32'hDEAD_BEEF));
            @(negedge clk);
        end

        // ---------------- reset while waiting
        do_reset();
        m_req = 2'b01;
        @(negedge clk);
        m_req = 2'b00;
        check("rw.gnt", 64'(m_gnt), 64'(2'b01));
        repeat (2) @(negedge clk);
        check("rw.busy_pre", 64'(busy), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        e = '0;
        check_outs("rw.after_rst", e);
        data_rvalid = 1'b1;
        data_rdata = 32'h7777_7777;
        @(negedge clk);
        data_rvalid = 1'b0;
        check("rw.no_rvalid", 64'(m_rvalid), 64'(0));
        check("rw.busy", 64'(busy), 64'(0));
        m_req = 2'b11;
        @(negedge clk);
        m_req = 2'b00;
        check("rw.tie_gnt", 64'(m_gnt), 64'(2'b01));

        // ---------------- randomized run against the reference model
        do_reset();
        model_reset();
        silent = 0;
        for (int c = 0; c < 1500; c++) begin
            e.dreq  = md_active && (c == md_issue);
            e.we    = md_we;
            e.gnt   = e.dreq ? (md_own ? 2'b10 : 2'b01) : 2'b00;
            e.rv    = md_rv;
            e.err   = md_err;
            e.rdata = md_rdata;
            e.be    = md_be;
            e.addr  = md_addr;
            e.wdata = md_wdata;
            e.busy  = md_active;
            check_outs("rand", e);

            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) silent = ~silent;
            m_req = 2'($urandom);
            m_we = 2'($urandom);
            m_be[0] = 4'($urandom);
            m_be[1] = 4'($urandom);
            m_addr[0] = $urandom;
            m_addr[1] = $urandom;
            m_wdata[0] = $urandom;
            m_wdata[1] = $urandom;
            data_rvalid = silent ? 1'b0 : ($urandom_range(0, 3) == 0);
            data_rdata = $urandom;

            // Model: transaction issues the cycle after acceptance; the slave may
            // answer from the issue cycle on; silence ends T cycles after issue.
            md_rv = '0;
            md_err = '0;
            if (rst) begin
                model_reset();
            end else if (md_active) begin
                if (data_rvalid) begin
                    md_rv = md_own ? 2'b10 : 2'b01;
                    md_rdata = data_rdata;
                    md_active = 0;
                end else if (c == md_issue + T) begin
                    md_rv = md_own ? 2'b10 : 2'b01;
                    md_err = md_rv;
                    md_rdata = 32'hDEAD_BEEF;
                    md_active = 0;
                end
            end else if (m_req != 2'b00) begin
                if (m_req == 2'b11) md_own = ~md_last;
                else md_own = m_req[1];
                md_last = md_own;
                md_we = m_we[md_own];
                md_be = m_be[md_own];
                md_addr = m_addr[md_own];
                md_wdata = m_wdata[md_own];
                md_active = 1;
                md_issue = c + 1;
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_data_arbiter.md
Name: rv_data_arbiter

Overview:
- Shares the single data-memory bus in front of rv_mmu between two requesters: master 0 (core LSU) and master 1 (program loader / debug port).
- Round-robin arbitration; at most one transaction outstanding.
- Registered request issue and registered response return.
- Watchdog terminates transactions the slave never answers, with an error response.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles spent in WAIT before a forced error response (legal range 2..255).
- ERR_RDATA, 32'hDEAD_BEEF, rdata returned on timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- m_req_i  in  2  per-master request; held until the matching m_gnt_o bit is seen
- m_we_i  in  2  per-master write enable
- m_be_i  in  2 x XLEN/8  per-master byte enables
- m_addr_i  in  2 x XLEN  per-master address
- m_wdata_i  in  2 x XLEN  per-master write data
- m_gnt_o  out  2  one-cycle grant pulse; the master may drop or change its request next cycle
- m_rvalid_o  out  2  one-cycle response pulse to the owner
- m_rdata_o  out  XLEN  response data, shared; valid only with m_rvalid_o
- m_err_o  out  2  one-cycle timeout flag, coincident with m_rvalid_o
- data_req_o  out  1  request to rv_mmu
- data_we_o  out  1  write enable to rv_mmu
- data_be_o  out  XLEN/8  byte enables to rv_mmu
- data_addr_o  out  XLEN  address to rv_mmu
- data_wdata_o  out  XLEN  write data to rv_mmu
- data_rvalid_i  in  1  response valid from rv_mmu; one pulse per request, reads and writes
- data_rdata_i  in  XLEN  response data from rv_mmu
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset values: state IDLE; all outputs 0; owner 0; last_grant 1 (master 0 wins the first tie); timeout counter 0.
- IDLE, cycle N, any m_req_i set:
  - winner = the only requester; on a tie, the master that is not last_grant.
  - Latch the winner's we/be/addr/wdata; last_grant <= winner; owner <= winner; go to ISSUE.
- ISSUE, cycle N+1:
  - data_req_o = 1 with the latched fields; m_gnt_o[owner] = 1.
  - If data_rvalid_i = 1 in this cycle (zero-wait slave), capture the response and go to IDLE.
  - Otherwise go to WAIT with the counter cleared.
- WAIT:
  - data_req_o = 0; counter increments every cycle.
  - data_rvalid_i = 1: capture data_rdata_i, go to IDLE.
  - Counter reaches TIMEOUT_CYCLES-1 without rvalid: capture ERR_RDATA with the error flag set, go to IDLE.
  - If rvalid and timeout occur in the same cycle, rvalid wins and no error is flagged.
- Response: registered. m_rvalid_o[owner] pulses in the cycle after capture (the first IDLE cycle), together with m_rdata_o and m_err_o[owner].
- Arbitration during the response cycle: IDLE arbitrates in that same cycle, so back-to-back throughput is one transaction per 3 cycles with a 1-cycle slave.
- data_rvalid_i while in IDLE (late response after a timeout) is ignored and does not disturb state.
- Request latency: m_req_i to data_req_o is exactly 1 cycle. Read latency: slave rvalid to m_rvalid_o is exactly 1 cycle.
- Requests seen in ISSUE or WAIT are not latched; they are re-evaluated in IDLE.
- m_rdata_o holds its last value when no response is pending; be/addr/wdata outputs hold the latched values while busy.
- Reset asserted mid-transaction: abort immediately. No pending m_rvalid_o is emitted after reset; any later slave rvalid is ignored in IDLE.

Decomposition:
- rv_pkg: XLEN (existing); arb_state_t enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT}; N_DATA_MASTERS = 2.
- No sub-module; the round-robin pick is a small function local to the block.

Test Plan:
- Single read: m0 requests addr 32'h0000_0100, slave returns 32'h1234_5678 one cycle after data_req_o -> data_req_o at N+1, m_gnt_o = 2'b01 at N+1, m_rvalid_o = 2'b01 with rdata 32'h1234_5678 at N+3, m_err_o = 0.
- Tie fairness: m0 and m1 request continuously with 1-cycle slave -> grants alternate 01, 10, 01, 10 starting with m0; each transaction spaced 3 cycles.
- Zero-wait slave: data_rvalid_i high in the ISSUE cycle for an m1 write to 32'h8000_0000 -> m_rvalid_o = 2'b10 the next cycle; the FSM never enters WAIT.
- Timeout: slave silent after an m1 read -> after TIMEOUT_CYCLES=16 WAIT cycles, m_rvalid_o = 2'b10, m_err_o = 2'b10, rdata 32'hDEAD_BEEF. A late slave rvalid 3 cycles later is ignored, with no extra pulse.
- Reset mid-WAIT: assert rst_i for 1 cycle while waiting -> next cycle all outputs 0, busy_o = 0. The subsequent slave rvalid produces no m_rvalid_o, and the next tie grants m0.
